// File: rtl/ghost_mode_if.sv
// Ghost mode scheduler bus: game controls in, per-ghost mode flags out.
// The game controller is the master; the scheduler is the slave.
interface ghost_mode_if;
  logic       start;
  logic       pause;
  logic       frightReq;
  logic       isScatter;
  logic       isChase;
  logic       isFrightened;
  logic       isFlashing;
  logic       modeChange;
  logic [2:0] phase;

  modport master (
    output start, pause, frightReq,
    input  isScatter, isChase, isFrightened, isFlashing, modeChange, phase
  );

  modport slave (
    input  start, pause, frightReq,
    output isScatter, isChase, isFrightened, isFlashing, modeChange, phase
  );
endinterface

// File: rtl/ghost_mode_timer.sv
// Global scatter/chase/frightened scheduler driving every ghost FSM.
// Seven timed phases run in whole seconds; a power pellet pre-empts them with a frightened interval.
module ghost_mode_timer #(
  parameter int unsigned SEC_DIV       = 25_000_000,
  parameter int unsigned SCATTER_A_SEC = 7,
  parameter int unsigned SCATTER_B_SEC = 5,
  parameter int unsigned CHASE_SEC     = 20,
  parameter int unsigned FRIGHT_SEC    = 6,
  parameter int unsigned FLASH_SEC     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  ghost_mode_if.slave bus
);

  localparam int unsigned PW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(SEC_DIV - 1);
  localparam logic [4:0]    DUR_A       = 5'(SCATTER_A_SEC);
  localparam logic [4:0]    DUR_B       = 5'(SCATTER_B_SEC);
  localparam logic [4:0]    DUR_CHASE   = 5'(CHASE_SEC);
  localparam logic [3:0]    FRIGHT_LOAD = 4'(FRIGHT_SEC);
  localparam logic [3:0]    FLASH_LIM   = 4'(FLASH_SEC);
  localparam logic [2:0]    LAST_PHASE  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FRIGHT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [4:0]    sec_left_q, sec_left_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] fr_presc_q, fr_presc_d;
  logic [3:0]    fright_left_q, fright_left_d;
  logic          is_scatter_q, is_scatter_d;
  logic          is_chase_q, is_chase_d;
  logic          is_frightened_q, is_frightened_d;
  logic          is_flashing_q, is_flashing_d;
  logic          mode_change_q, mode_change_d;
  logic          sec_tick;
  logic          fr_tick;

  // Phase 7 has no duration: the schedule parks there in chase forever.
  function automatic logic [4:0] phase_duration(input logic [2:0] p);
    logic [4:0] d;
    case (p)
      3'd0, 3'd2:       d = DUR_A;
      3'd1, 3'd3, 3'd5: d = DUR_CHASE;
      3'd4, 3'd6:       d = DUR_B;
      default:          d = 5'd0;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    sec_left_d    = sec_left_q;
    presc_d       = presc_q;
    fr_presc_d    = fr_presc_q;
    fright_left_d = fright_left_q;
    mode_change_d = 1'b0;
    sec_tick      = 1'b0;
    fr_tick       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end

      ST_RUN: begin
        if (!bus.pause) begin
          sec_tick = (presc_q == PRESC_MAX);
          presc_d  = sec_tick ? '0 : presc_q + 1'b1;
        end
        // A pellet wins over a coincident second tick; that tick's decrement is dropped.
        if (bus.frightReq) begin
          state_d       = ST_FRIGHT;
          fright_left_d = FRIGHT_LOAD;
          fr_presc_d    = '0;
          mode_change_d = 1'b1;
        end else if (sec_tick && (phase_q != LAST_PHASE)) begin
          if (sec_left_q == 5'd1) begin
            phase_d       = phase_q + 3'd1;
            sec_left_d    = phase_duration(phase_q + 3'd1);
            mode_change_d = 1'b1;
          end else begin
            sec_left_d = sec_left_q - 5'd1;
          end
        end
      end

      ST_FRIGHT: begin
        if (bus.frightReq) begin
          fright_left_d = FRIGHT_LOAD;
          fr_presc_d    = '0;
        end else if (!bus.pause) begin
          fr_tick    = (fr_presc_q == PRESC_MAX);
          fr_presc_d = fr_tick ? '0 : fr_presc_q + 1'b1;
          if (fr_tick) begin
            fright_left_d = fright_left_q - 4'd1;
            if (fright_left_q == 4'd1) begin
              state_d = ST_RUN;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping start reinitialises the whole schedule, whatever else is pending.
    if (!bus.start) begin
      state_d       = ST_IDLE;
      phase_d       = 3'd0;
      sec_left_d    = DUR_A;
      presc_d       = '0;
      fr_presc_d    = '0;
      fright_left_d = 4'd0;
      mode_change_d = 1'b0;
    end

    // Outputs are derived from next state so they land on the same edge as the cause.
    is_frightened_d = (state_d == ST_FRIGHT);
    is_scatter_d    = (state_d != ST_FRIGHT) && !phase_d[0] && (phase_d != LAST_PHASE);
    is_chase_d      = (state_d == ST_RUN) && !is_scatter_d;
    is_flashing_d   = is_frightened_d && (fright_left_d <= FLASH_LIM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      phase_q         <= 3'd0;
      sec_left_q      <= DUR_A;
      presc_q         <= '0;
      fr_presc_q      <= '0;
      fright_left_q   <= 4'd0;
      is_scatter_q    <= 1'b1;
      is_chase_q      <= 1'b0;
      is_frightened_q <= 1'b0;
      is_flashing_q   <= 1'b0;
      mode_change_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      sec_left_q      <= sec_left_d;
      presc_q         <= presc_d;
      fr_presc_q      <= fr_presc_d;
      fright_left_q   <= fright_left_d;
      is_scatter_q    <= is_scatter_d;
      is_chase_q      <= is_chase_d;
      is_frightened_q <= is_frightened_d;
      is_flashing_q   <= is_flashing_d;
      mode_change_q   <= mode_change_d;
    end
  end

  assign bus.isScatter    = is_scatter_q;
  assign bus.isChase      = is_chase_q;
  assign bus.isFrightened = is_frightened_q;
  assign bus.isFlashing   = is_flashing_q;
  assign bus.modeChange   = mode_change_q;
  assign bus.phase        = phase_q;

endmodule
